// File: rtl/core_mem_stage_if.sv
// ---------------------------------------------------------------------------
// core_mem_stage_if
// Data-memory bus between the MEM pipeline stage (master) and the data
// memory (slave).
//   dmem_req   : request, held until dmem_ack
//   dmem_we    : request is a store
//   dmem_addr  : doubleword-aligned address
//   dmem_wdata : lane-aligned store data
//   dmem_be    : byte enables
//   dmem_rdata : read data, qualified by dmem_ack
//   dmem_ack   : memory acknowledge
// ---------------------------------------------------------------------------
interface core_mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_be;
  logic [63:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/core_mem_stage.sv
// ---------------------------------------------------------------------------
// core_mem_stage
// MEM pipeline stage: passes ALU results through, performs byte / word /
// dword loads and stores on the data-memory bus, stalls upstream while a
// request is outstanding, and flags misaligned accesses and ack timeouts.
// Ports:
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   ex_*                : EX-stage result, operands and memory-op controls
//   dmem                : data-memory bus (master side)
//   stall               : upstream must hold its EX inputs
//   MEM_data/W_regnum/write_enable : registered stage result
//   addr_error          : one-cycle pulse, misaligned access dropped
//   bus_error           : one-cycle pulse, no ack within TIMEOUT_CYCLES
// ---------------------------------------------------------------------------
module core_mem_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ex_valid,
  input  logic [63:0]             ex_out,
  input  logic [63:0]             ex_B_data,
  input  logic [1:0]              ex_load_type,
  input  logic [1:0]              ex_store_type,
  input  logic                    ex_signed,
  input  logic [4:0]              ex_W_regnum,
  input  logic                    ex_write_enable,
  core_mem_stage_if.master        dmem,
  output logic                    stall,
  output logic [63:0]             MEM_data,
  output logic [4:0]              MEM_W_regnum,
  output logic                    MEM_write_enable,
  output logic                    addr_error,
  output logic                    bus_error
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Counter value in the last BUSY cycle before the bus error is declared.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_stall;
  logic              w_is_store;
  logic              w_is_load;
  logic              w_mem_op;
  logic [1:0]        w_size;
  logic [2:0]        w_ofs;
  logic              w_aligned;
  logic              w_timeout;

  logic              r_req;
  logic              r_we;
  logic [63:0]       r_addr;
  logic [63:0]       r_wdata;
  logic [7:0]        r_be;
  logic [1:0]        r_size;
  logic [2:0]        r_ofs;
  logic              r_signed;
  logic [4:0]        r_regnum;
  logic              r_wen;
  logic [CNT_W-1:0]  r_wait;
  logic [63:0]       r_mem_data;
  logic [4:0]        r_mem_regnum;
  logic              r_mem_we;
  logic              r_addr_error;
  logic              r_bus_error;

  function automatic logic [7:0] byte_enables(input logic [1:0] size, input logic [2:0] ofs);
    case (size)
      2'd1:    byte_enables = 8'h01 << ofs;
      2'd2:    byte_enables = 8'h0F << ofs;
      2'd3:    byte_enables = 8'hFF;
      default: byte_enables = 8'h00;
    endcase
  endfunction

  // Shift the addressed lane down, then truncate and extend to 64 bits.
  function automatic logic [63:0] format_load(input logic [63:0] rdata, input logic [2:0] ofs,
                                              input logic [1:0] size, input logic sgn);
    logic [63:0] sh;
    sh = rdata >> {ofs, 3'b000};
    case (size)
      2'd1:    format_load = sgn ? {{56{sh[7]}}, sh[7:0]} : {56'd0, sh[7:0]};
      2'd2:    format_load = sgn ? {{32{sh[31]}}, sh[31:0]} : {32'd0, sh[31:0]};
      default: format_load = sh;
    endcase
  endfunction

  assign w_is_store = (ex_store_type != 2'd0);
  assign w_is_load  = (ex_load_type != 2'd0);
  assign w_mem_op   = ex_valid & (w_is_store | w_is_load);
  // Store wins when both load and store types are set.
  assign w_size     = w_is_store ? ex_store_type : ex_load_type;
  assign w_ofs      = ex_out[2:0];
  assign w_timeout  = (r_state == ST_BUSY) && !dmem.dmem_ack && (r_wait == TIMEOUT_LAST);

  // Alignment check for the incoming access size.
  always_comb begin
    w_aligned = 1'b1;
    case (w_size)
      2'd1:    w_aligned = 1'b1;
      2'd2:    w_aligned = (w_ofs[1:0] == 2'd0);
      2'd3:    w_aligned = (w_ofs == 3'd0);
      default: w_aligned = 1'b1;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and combinational stall.
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_mem_op && w_aligned) begin
          w_state_nxt = ST_BUSY;
          w_stall     = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (dmem.dmem_ack || w_timeout) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request latching, wait counter, stage result and error pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= 64'd0;
      r_wdata      <= 64'd0;
      r_be         <= 8'd0;
      r_size       <= 2'd0;
      r_ofs        <= 3'd0;
      r_signed     <= 1'b0;
      r_regnum     <= 5'd0;
      r_wen        <= 1'b0;
      r_wait       <= '0;
      r_mem_data   <= 64'd0;
      r_mem_regnum <= 5'd0;
      r_mem_we     <= 1'b0;
      r_addr_error <= 1'b0;
      r_bus_error  <= 1'b0;
    end else begin
      r_addr_error <= 1'b0;
      r_bus_error  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_wait <= '0;
          if (w_mem_op && w_aligned) begin
            r_req    <= 1'b1;
            r_we     <= w_is_store;
            r_addr   <= {ex_out[63:3], 3'b000};
            r_wdata  <= ex_B_data << {w_ofs, 3'b000};
            r_be     <= byte_enables(w_size, w_ofs);
            r_size   <= w_size;
            r_ofs    <= w_ofs;
            r_signed <= ex_signed;
            r_regnum <= ex_W_regnum;
            r_wen    <= ex_write_enable;
          end else if (w_mem_op) begin
            r_addr_error <= 1'b1;
            r_mem_data   <= ex_out;
            r_mem_regnum <= ex_W_regnum;
            r_mem_we     <= 1'b0;
          end else begin
            // Bubbles (ex_valid low) never write the register file.
            r_mem_data   <= ex_out;
            r_mem_regnum <= ex_W_regnum;
            r_mem_we     <= ex_valid & ex_write_enable;
          end
        end
        ST_BUSY: begin
          if (dmem.dmem_ack) begin
            r_req <= 1'b0;
            if (r_we) begin
              r_mem_we <= 1'b0;
            end else begin
              r_mem_data   <= format_load(dmem.dmem_rdata, r_ofs, r_size, r_signed);
              r_mem_regnum <= r_regnum;
              r_mem_we     <= r_wen;
            end
          end else if (w_timeout) begin
            r_req       <= 1'b0;
            r_mem_we    <= 1'b0;
            r_bus_error <= 1'b1;
          end else begin
            r_wait <= r_wait + CNT_W'(1);
          end
        end
        default: r_req <= 1'b0;
      endcase
    end
  end

  assign dmem.dmem_req   = r_req;
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_addr  = r_addr;
  assign dmem.dmem_wdata = r_wdata;
  assign dmem.dmem_be    = r_be;

  assign stall            = w_stall;
  assign MEM_data         = r_mem_data;
  assign MEM_W_regnum     = r_mem_regnum;
  assign MEM_write_enable = r_mem_we;
  assign addr_error       = r_addr_error;
  assign bus_error        = r_bus_error;

endmodule

// File: tb/tb_core_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_core_mem_stage
// Directed self-checking bench for core_mem_stage (TIMEOUT_CYCLES = 4).
// Inputs change on the falling edge; outputs are sampled on the falling edge
// or 1 ns after it for the combinational stall.
// ---------------------------------------------------------------------------
module tb_core_mem_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [63:0] ex_out;
  logic [63:0] ex_B_data;
  logic [1:0]  ex_load_type;
  logic [1:0]  ex_store_type;
  logic        ex_signed;
  logic [4:0]  ex_W_regnum;
  logic        ex_write_enable;
  logic        stall;
  logic [63:0] MEM_data;
  logic [4:0]  MEM_W_regnum;
  logic        MEM_write_enable;
  logic        addr_error;
  logic        bus_error;

  int n_checks = 0;
  int n_errors = 0;

  core_mem_stage_if u_bus ();

  core_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clock            (clock),
    .reset            (reset),
    .ex_valid         (ex_valid),
    .ex_out           (ex_out),
    .ex_B_data        (ex_B_data),
    .ex_load_type     (ex_load_type),
    .ex_store_type    (ex_store_type),
    .ex_signed        (ex_signed),
    .ex_W_regnum      (ex_W_regnum),
    .ex_write_enable  (ex_write_enable),
    .dmem             (u_bus),
    .stall            (stall),
    .MEM_data         (MEM_data),
    .MEM_W_regnum     (MEM_W_regnum),
    .MEM_write_enable (MEM_write_enable),
    .addr_error       (addr_error),
    .bus_error        (bus_error)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    ex_valid        = 1'b0;
    ex_out          = 64'd0;
    ex_B_data       = 64'd0;
    ex_load_type    = 2'd0;
    ex_store_type   = 2'd0;
    ex_signed       = 1'b0;
    ex_W_regnum     = 5'd0;
    ex_write_enable = 1'b0;
  endtask

  task automatic drive_op(input logic [63:0] addr, input logic [63:0] bdata, input logic [1:0] lt,
                          input logic [1:0] st, input logic sgn, input logic [4:0] rn, input logic we);
    ex_valid        = 1'b1;
    ex_out          = addr;
    ex_B_data       = bdata;
    ex_load_type    = lt;
    ex_store_type   = st;
    ex_signed       = sgn;
    ex_W_regnum     = rn;
    ex_write_enable = we;
  endtask

  initial begin
    reset            = 1'b1;
    u_bus.dmem_ack   = 1'b0;
    u_bus.dmem_rdata = 64'd0;
    set_idle();
    #2;
    check_eq("rst_req",   {63'd0, u_bus.dmem_req}, 64'd0);
    check_eq("rst_data",  MEM_data, 64'd0);
    check_eq("rst_mwe",   {63'd0, MEM_write_enable}, 64'd0);
    check_eq("rst_stall", {63'd0, stall}, 64'd0);
    check_eq("rst_be",    {56'd0, u_bus.dmem_be}, 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // ALU passthrough
    drive_op(64'h1234, 64'd0, 2'd0, 2'd0, 1'b0, 5'd5, 1'b1);
    #1 check_eq("pass_stall", {63'd0, stall}, 64'd0);
    @(negedge clock);
    check_eq("pass_data",  MEM_data, 64'h1234);
    check_eq("pass_rn",    {59'd0, MEM_W_regnum}, 64'd5);
    check_eq("pass_we",    {63'd0, MEM_write_enable}, 64'd1);
    check_eq("pass_stall2", {63'd0, stall}, 64'd0);

    // Signed byte load, ack two cycles after req
    drive_op(64'h1003, 64'd0, 2'd1, 2'd0, 1'b1, 5'd7, 1'b1);
    #1 check_eq("lb_stall0", {63'd0, stall}, 64'd1);
    @(negedge clock);
    check_eq("lb_req",   {63'd0, u_bus.dmem_req}, 64'd1);
    check_eq("lb_be",    {56'd0, u_bus.dmem_be}, 64'h08);
    check_eq("lb_addr",  u_bus.dmem_addr, 64'h1000);
    check_eq("lb_we",    {63'd0, u_bus.dmem_we}, 64'd0);
    check_eq("lb_stall1", {63'd0, stall}, 64'd1);
    check_eq("lb_hold",  MEM_data, 64'h1234);
    @(negedge clock);
    check_eq("lb_stall2", {63'd0, stall}, 64'd1);
    u_bus.dmem_ack   = 1'b1;
    u_bus.dmem_rdata = 64'h00000000_80000000;
    #1 check_eq("lb_stall_ack", {63'd0, stall}, 64'd0);
    @(negedge clock);
    u_bus.dmem_ack = 1'b0;
    set_idle();
    check_eq("lb_data", MEM_data, 64'hFFFFFFFF_FFFFFF80);
    check_eq("lb_rn",   {59'd0, MEM_W_regnum}, 64'd7);
    check_eq("lb_mwe",  {63'd0, MEM_write_enable}, 64'd1);
    check_eq("lb_req_drop", {63'd0, u_bus.dmem_req}, 64'd0);

    // Word store (load_type also set: store must win)
    @(negedge clock);
    drive_op(64'h2004, 64'hAABBCCDD, 2'd1, 2'd2, 1'b0, 5'd3, 1'b1);
    #1 check_eq("sw_stall0", {63'd0, stall}, 64'd1);
    @(negedge clock);
    check_eq("sw_addr",  u_bus.dmem_addr, 64'h2000);
    check_eq("sw_be",    {56'd0, u_bus.dmem_be}, 64'hF0);
    check_eq("sw_wdata", {32'd0, u_bus.dmem_wdata[63:32]}, 64'hAABBCCDD);
    check_eq("sw_we",    {63'd0, u_bus.dmem_we}, 64'd1);
    u_bus.dmem_ack = 1'b1;
    #1 check_eq("sw_stall_ack", {63'd0, stall}, 64'd0);
    @(negedge clock);
    u_bus.dmem_ack = 1'b0;
    set_idle();
    check_eq("sw_mwe", {63'd0, MEM_write_enable}, 64'd0);
    check_eq("sw_req_drop", {63'd0, u_bus.dmem_req}, 64'd0);

    // Aligned dword load
    drive_op(64'h10, 64'd0, 2'd3, 2'd0, 1'b0, 5'd9, 1'b1);
    #1 check_eq("ld_stall0", {63'd0, stall}, 64'd1);
    @(negedge clock);
    check_eq("ld_req", {63'd0, u_bus.dmem_req}, 64'd1);
    check_eq("ld_be",  {56'd0, u_bus.dmem_be}, 64'hFF);
    u_bus.dmem_ack   = 1'b1;
    u_bus.dmem_rdata = 64'h01234567_89ABCDEF;
    @(negedge clock);
    u_bus.dmem_ack = 1'b0;
    set_idle();
    check_eq("ld_data", MEM_data, 64'h01234567_89ABCDEF);
    check_eq("ld_rn",   {59'd0, MEM_W_regnum}, 64'd9);

    // Misaligned dword load
    drive_op(64'h14, 64'd0, 2'd3, 2'd0, 1'b0, 5'd4, 1'b1);
    #1 check_eq("mis_stall", {63'd0, stall}, 64'd0);
    @(negedge clock);
    set_idle();
    check_eq("mis_aerr", {63'd0, addr_error}, 64'd1);
    check_eq("mis_req",  {63'd0, u_bus.dmem_req}, 64'd0);
    check_eq("mis_mwe",  {63'd0, MEM_write_enable}, 64'd0);
    check_eq("mis_data", MEM_data, 64'h14);
    @(negedge clock);
    check_eq("mis_aerr_pulse", {63'd0, addr_error}, 64'd0);

    // Unsigned word load from upper lane
    drive_op(64'h24, 64'd0, 2'd2, 2'd0, 1'b0, 5'd11, 1'b1);
    @(negedge clock);
    check_eq("lw_be", {56'd0, u_bus.dmem_be}, 64'hF0);
    u_bus.dmem_ack   = 1'b1;
    u_bus.dmem_rdata = 64'h89ABCDEF_00000000;
    @(negedge clock);
    u_bus.dmem_ack = 1'b0;
    set_idle();
    check_eq("lw_data", MEM_data, 64'h00000000_89ABCDEF);
    check_eq("lw_mwe",  {63'd0, MEM_write_enable}, 64'd1);

    // Timeout: 4 BUSY cycles without ack
    drive_op(64'h30, 64'd0, 2'd1, 2'd0, 1'b0, 5'd2, 1'b1);
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      check_eq("to_stall", {63'd0, stall}, 64'd1);
      check_eq("to_req",   {63'd0, u_bus.dmem_req}, 64'd1);
      @(negedge clock);
    end
    check_eq("to_stall_last", {63'd0, stall}, 64'd0);
    check_eq("to_berr_early", {63'd0, bus_error}, 64'd0);
    set_idle();
    @(negedge clock);
    check_eq("to_berr",  {63'd0, bus_error}, 64'd1);
    check_eq("to_req_drop", {63'd0, u_bus.dmem_req}, 64'd0);
    check_eq("to_mwe",   {63'd0, MEM_write_enable}, 64'd0);
    check_eq("to_stall_idle", {63'd0, stall}, 64'd0);
    @(negedge clock);
    check_eq("to_berr_pulse", {63'd0, bus_error}, 64'd0);

    // Reset asserted mid-BUSY
    drive_op(64'h40, 64'd0, 2'd1, 2'd0, 1'b0, 5'd6, 1'b1);
    @(negedge clock);
    check_eq("rb_req", {63'd0, u_bus.dmem_req}, 64'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("rb_req_now", {63'd0, u_bus.dmem_req}, 64'd0);
    check_eq("rb_addr",    u_bus.dmem_addr, 64'd0);
    check_eq("rb_data",    MEM_data, 64'd0);
    set_idle();
    @(negedge clock);
    reset = 1'b0;
    u_bus.dmem_ack   = 1'b1;
    u_bus.dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clock);
    u_bus.dmem_ack = 1'b0;
    check_eq("rb_ack_ign_mwe",  {63'd0, MEM_write_enable}, 64'd0);
    check_eq("rb_ack_ign_data", MEM_data, 64'd0);
    check_eq("rb_ack_ign_req",  {63'd0, u_bus.dmem_req}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/core_mem_stage.md
CORE_MEM_STAGE -- requirements
Module: core_mem_stage

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum number of wait cycles for a data-memory acknowledge before a bus error is declared.
REQ-002 The module SHALL have the port clock, input, 1 bit, the rising-edge clock.
REQ-003 The module SHALL have the port reset, input, 1 bit, an asynchronous active-high reset.
REQ-004 The module SHALL have the port ex_valid, input, 1 bit, meaning the EX result is valid this cycle.
REQ-005 The module SHALL have the port ex_out, input, 64 bits, carrying the EX ALU result, used as address for memory operations.
REQ-006 The module SHALL have the port ex_B_data, input, 64 bits, carrying the forwarded store data.
REQ-007 The module SHALL have the port ex_load_type, input, 2 bits: 0 none, 1 byte, 2 word32, 3 dword.
REQ-008 The module SHALL have the port ex_store_type, input, 2 bits, with the same encoding as ex_load_type.
REQ-009 The module SHALL have the port ex_signed, input, 1 bit, selecting a sign-extended load.
REQ-010 The module SHALL have the port ex_W_regnum, input, 5 bits, the destination register.
REQ-011 The module SHALL have the port ex_write_enable, input, 1 bit, the register write enable.
REQ-012 The module SHALL have the port dmem_rdata, input, 64 bits, the memory read data.
REQ-013 The module SHALL have the port dmem_ack, input, 1 bit, the memory acknowledge, qualifying dmem_rdata.
REQ-014 The module SHALL have the port dmem_req, output, 1 bit, the request, held until ack.
REQ-015 The module SHALL have the port dmem_we, output, 1 bit, meaning the request is a store.
REQ-016 The module SHALL have the port dmem_addr, output, 64 bits, the address {addr[63:3],3'b0}.
REQ-017 The module SHALL have the port dmem_wdata, output, 64 bits, the lane-aligned store data.
REQ-018 The module SHALL have the port dmem_be, output, 8 bits, the byte enables.
REQ-019 The module SHALL have the port stall, output, 1 bit; when it is high, upstream holds its EX inputs stable.
REQ-020 The module SHALL have the port MEM_data, output, 64 bits, the registered result, also used as the forwarding source.
REQ-021 The module SHALL have the port MEM_W_regnum, output, 5 bits, the registered destination register.
REQ-022 The module SHALL have the port MEM_write_enable, output, 1 bit, the registered write enable.
REQ-023 The module SHALL have the port addr_error, output, 1 bit, a one-cycle registered pulse flagging a misaligned access.
REQ-024 The module SHALL have the port bus_error, output, 1 bit, a one-cycle registered pulse flagging an ack timeout.

Function
REQ-025 The FSM SHALL have states IDLE and BUSY.
REQ-026 A memory op SHALL be defined as ex_valid with load_type!=0 or store_type!=0; if both are nonzero, the store SHALL take priority.
REQ-027 Alignment SHALL be as follows: byte is always aligned; word requires addr[1:0]==0; dword requires addr[2:0]==0.
REQ-028 Byte enables SHALL be: byte = 8'h01<<addr[2:0]; word = 8'h0F<<addr[2:0]; dword = 8'hFF.
REQ-029 dmem_wdata SHALL be ex_B_data shifted left by 8*addr[2:0]; bytes outside the enables are don't-care.
REQ-030 Load data SHALL be computed as dmem_rdata>>8*addr[2:0], truncated to the access size, then sign-extended if ex_signed else zero-extended to 64 bits; dword loads SHALL pass through unchanged.
REQ-031 For a non-memory op in IDLE, stall SHALL be 0, and on the next edge MEM_data=ex_out, with MEM_W_regnum and MEM_write_enable copied from the inputs (1-cycle latency).
REQ-032 For a misaligned memory op in IDLE: no request SHALL be issued, stall SHALL be 0, and on the next edge addr_error=1, MEM_write_enable=0, MEM_data=ex_out.
REQ-033 For an aligned memory op in IDLE: stall SHALL be 1 combinationally; at the edge the module SHALL latch addr, be, wdata, we, size, signed and regnum, and move to BUSY with dmem_req=1 (registered).
REQ-034 In BUSY, dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata SHALL hold constant until ack.
REQ-035 In BUSY, stall SHALL be 1 unless dmem_ack=1.
REQ-036 In BUSY with dmem_ack=1, stall SHALL be 0, and at the edge: a load SHALL write the formatted data to MEM_data with the latched regnum and write_enable; a store SHALL set MEM_write_enable=0; dmem_req SHALL go to 0 and the state to IDLE.
REQ-037 Load-use latency SHALL be the ack cycle plus 1.
REQ-038 A new op SHALL NOT be accepted in the ack cycle; the next op is sampled in IDLE one cycle later.
REQ-039 While stall=1, the outputs MEM_data, MEM_W_regnum and MEM_write_enable SHALL hold their previous values.
REQ-040 A wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack.
REQ-041 When the wait counter reaches TIMEOUT_CYCLES with no ack, at that edge the module SHALL set bus_error=1, dmem_req=0, MEM_write_enable=0 and state IDLE; stall SHALL be 0 in that cycle.
REQ-042 dmem_ack received in IDLE SHALL be ignored.
REQ-043 addr_error and bus_error SHALL be high for exactly one cycle per event.

Reset
REQ-044 Asserting reset, including mid-BUSY, SHALL immediately force: state IDLE; dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_be all 0; MEM_data=0; MEM_W_regnum=0; MEM_write_enable=0; addr_error=0; bus_error=0; wait counter 0.
REQ-045 stall SHALL be 0 after reset unless an aligned memory op is present on the inputs.

Verification
REQ-046 ALU passthrough: ex_out=64'h1234, write_enable=1, regnum=5 -> next cycle MEM_data=64'h1234, MEM_W_regnum=5, stall never high.
REQ-047 Signed byte load: addr=64'h1003, rdata=64'h00000000_80000000, ack two cycles after req -> be=8'h08, MEM_data=64'hFFFFFFFF_FFFFFF80 one cycle after ack, stall high exactly 3 cycles.
REQ-048 Word store: addr=64'h2004, B_data=64'hAABBCCDD -> dmem_addr=64'h2000, be=8'hF0, wdata[63:32]=32'hAABBCCDD, we=1, MEM_write_enable=0.
REQ-049 Misaligned dword: addr=64'h10, load_type=3 -> accepted (aligned); addr=64'h14, load_type=3 -> addr_error pulse, no dmem_req, MEM_write_enable=0.
REQ-050 Timeout with TIMEOUT_CYCLES=4 and no ack -> bus_error pulse, dmem_req drops, stall released, FSM back in IDLE.
REQ-051 Reset asserted in BUSY -> dmem_req=0 immediately; a later ack is ignored; MEM_write_enable=0.
